// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: FSM states,
// mux select encodings, trap causes and the latched decoder class flags.
package rv_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_e;

  localparam logic [1:0] PCSRC_PLUS4 = 2'd0;
  localparam logic [1:0] PCSRC_IMM   = 2'd1;
  localparam logic [1:0] PCSRC_JALR  = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE         = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL      = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TIMEOUT = 2'd3;

  localparam logic [4:0] ALUCTRL_ILLEGAL = 5'h0F;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic auipc;
    logic regwrite;
  } dec_flags_t;

endpackage

// File: rtl/rv_mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles, saturates at all-ones and
// flags the stall cycle whose increment reaches (or sits at) saturation.
module rv_mem_watchdog #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sat
);

  localparam logic [W-1:0] MAX  = {W{1'b1}};
  localparam logic [W-1:0] NEAR = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != MAX)) begin
      cnt_reg <= cnt_reg + ONE;
    end
  end

  assign sat = en && (cnt_reg >= NEAR);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory
// handshakes, a wait watchdog, a sticky trap and a retired counter.
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_branch,
  input  logic             dec_jal,
  input  logic             dec_jalr,
  input  logic             dec_auipc,
  input  logic             dec_regwrite,
  input  logic [4:0]       dec_aluctrl,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e     state_reg, state_next;
  dec_flags_t dec_flags, flags_reg, flags_next;
  logic [1:0] cause_next;
  logic       wd_clr, wd_en, wd_sat;

  logic       imem_req_next, ir_we_next, pc_we_next, alu_we_next;
  logic       dmem_req_next, dmem_we_next, rf_we_next, trap_next;
  logic       exec_branch_next, exec_branch_reg;
  logic [1:0] pc_src_next, pc_src_reg, wb_sel_next;
  logic [CNT_W-1:0] retired_reg;

  assign dec_flags  = {dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_auipc, dec_regwrite};
  assign flags_next = (state_reg == DECODE) ? dec_flags : flags_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      flags_reg <= flags_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = CAUSE_NONE;
    case (state_reg)
      FETCH: begin
        if (imem_ready) begin
          state_next = DECODE;
        end else if (wd_sat) begin
          state_next = TRAP;
          cause_next = CAUSE_IMEM_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_aluctrl == ALUCTRL_ILLEGAL) begin
          state_next = TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        if (flags_reg.branch)                        state_next = FETCH;
        else if (flags_reg.load || flags_reg.store)  state_next = MEM;
        else                                         state_next = WB;
      end
      MEM: begin
        if (dmem_ready) begin
          state_next = WB;
        end else if (wd_sat) begin
          state_next = TRAP;
          cause_next = CAUSE_DMEM_TIMEOUT;
        end
      end
      WB:      state_next = FETCH;
      default: state_next = TRAP;
    endcase
  end

  // Any state change is a state entry, so the watchdog restarts from zero.
  assign wd_clr = (state_next != state_reg);
  assign wd_en  = ((state_reg == FETCH) && !imem_ready) || ((state_reg == MEM) && !dmem_ready);

  rv_mem_watchdog #(.W(TIMEOUT_W)) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .sat   (wd_sat)
  );

  always_comb begin
    imem_req_next    = (state_next == FETCH);
    ir_we_next       = (state_reg == FETCH) && (state_next == DECODE);
    alu_we_next      = (state_next == EXECUTE);
    exec_branch_next = (state_next == EXECUTE) && flags_next.branch;
    dmem_req_next    = (state_next == MEM);
    dmem_we_next     = (state_next == MEM) && flags_next.store;
    pc_we_next       = exec_branch_next || (state_next == WB);
    rf_we_next       = (state_next == WB) && flags_next.regwrite && !flags_next.store;
    trap_next        = (state_next == TRAP);
    wb_sel_next      = WBSEL_ALU;
    pc_src_next      = PCSRC_PLUS4;
    if (state_next == WB) begin
      if (flags_next.load)                        wb_sel_next = WBSEL_MEM;
      else if (flags_next.jal || flags_next.jalr) wb_sel_next = WBSEL_PC4;
      else if (flags_next.auipc)                  wb_sel_next = WBSEL_ALU;
      if (flags_next.jal)       pc_src_next = PCSRC_IMM;
      else if (flags_next.jalr) pc_src_next = PCSRC_JALR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req        <= 1'b0;
      ir_we           <= 1'b0;
      pc_we           <= 1'b0;
      pc_src_reg      <= PCSRC_PLUS4;
      exec_branch_reg <= 1'b0;
      alu_we          <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      rf_we           <= 1'b0;
      wb_sel          <= WBSEL_ALU;
      trap            <= 1'b0;
      trap_cause      <= CAUSE_NONE;
      retired_reg     <= '0;
    end else begin
      imem_req        <= imem_req_next;
      ir_we           <= ir_we_next;
      pc_we           <= pc_we_next;
      pc_src_reg      <= pc_src_next;
      exec_branch_reg <= exec_branch_next;
      alu_we          <= alu_we_next;
      dmem_req        <= dmem_req_next;
      dmem_we         <= dmem_we_next;
      rf_we           <= rf_we_next;
      wb_sel          <= wb_sel_next;
      trap            <= trap_next;
      if (trap_next && !trap) trap_cause <= cause_next;
      if ((state_reg == WB) || ((state_reg == EXECUTE) && flags_reg.branch))
        retired_reg <= retired_reg + CNT_ONE;
    end
  end

  // br_taken is only valid during EXECUTE, so the branch target select
  // follows it live instead of waiting a cycle for a registered copy.
  assign pc_src  = exec_branch_reg ? {1'b0, br_taken} : pc_src_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: a per-instruction script model
// predicts every cycle's outputs; a single compare process checks them.
module tb_rv_multicycle_ctrl;

  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;

  // class flags {load, store, branch, jal, jalr, auipc, regwrite}
  localparam logic [6:0] F_ADDI  = 7'b0000001;
  localparam logic [6:0] F_LW    = 7'b1000001;
  localparam logic [6:0] F_SW    = 7'b0100000;
  localparam logic [6:0] F_SW_RW = 7'b0100001;
  localparam logic [6:0] F_BEQ   = 7'b0010000;
  localparam logic [6:0] F_JAL   = 7'b0001001;
  localparam logic [6:0] F_JALR  = 7'b0000101;
  localparam logic [6:0] F_AUIPC = 7'b0000011;

  typedef struct packed {
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        alu_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] retired;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic dec_load = 1'b0, dec_store = 1'b0, dec_branch = 1'b0, dec_jal = 1'b0;
  logic dec_jalr = 1'b0, dec_auipc = 1'b0, dec_regwrite = 1'b0;
  logic [4:0] dec_aluctrl = 5'h0;
  logic br_taken = 1'b0;
  logic imem_req, ir_we, pc_we, alu_we, dmem_req, dmem_we, rf_we, trap;
  logic [1:0] pc_src, wb_sel, trap_cause;
  logic [31:0] retired;

  rv_multicycle_ctrl #(.TIMEOUT_W(TW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_load(dec_load), .dec_store(dec_store), .dec_branch(dec_branch),
    .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_auipc(dec_auipc),
    .dec_regwrite(dec_regwrite), .dec_aluctrl(dec_aluctrl), .br_taken(br_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_we(alu_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  exp_t        expq[$];
  string       lit_name[$];
  logic [63:0] lit_got[$];
  logic [63:0] lit_exp[$];
  int          n_cmp = 0, n_fail = 0, cyc = 0;
  int          n_ireq = 0, n_dreq = 0, n_rfwe = 0, n_strobe = 0;

  int unsigned m_retired = 0;
  logic        m_trapped = 1'b0;
  logic [1:0]  m_cause = 2'd0;
  logic        fresh = 1'b0;

  // The one compare process: cycle-model entries and queued literal checks.
  always @(negedge clk) begin
    exp_t e, got;
    cyc++;
    n_ireq   += int'(imem_req);
    n_dreq   += int'(dmem_req);
    n_rfwe   += int'(rf_we);
    n_strobe += int'(imem_req | ir_we | pc_we | alu_we | dmem_req | dmem_we | rf_we);
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = {imem_req, ir_we, pc_we, pc_src, alu_we, dmem_req, dmem_we, rf_we,
             wb_sel, trap, trap_cause, retired};
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got ctl=%b ret=%0d, required ctl=%b ret=%0d",
                 cyc, got[45:32], got.retired, e[45:32], e.retired);
      end
    end
    while (lit_name.size() > 0) begin
      string nm;
      logic [63:0] g, x;
      nm = lit_name.pop_front();
      g  = lit_got.pop_front();
      x  = lit_exp.pop_front();
      n_cmp++;
      if (g !== x) begin
        n_fail++;
        $display("FAIL %s: got %0d, required %0d", nm, g, x);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] x);
    lit_name.push_back(nm);
    lit_got.push_back(g);
    lit_exp.push_back(x);
  endtask

  function automatic exp_t idle();
    exp_t e;
    e = '0;
    e.trap    = m_trapped;
    e.cause   = m_cause;
    e.retired = m_retired;
    return e;
  endfunction

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    {dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_auipc, dec_regwrite} = 7'($urandom);
    dec_aluctrl = 5'($urandom);
    br_taken    = 1'($urandom);
    imem_ready  = 1'($urandom);
    dmem_ready  = 1'($urandom);
  endtask

  task automatic model_reset();
    m_retired = 0;
    m_trapped = 1'b0;
    m_cause   = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      noise();
      step(idle());
    end
    rst_n = 1'b1;
    fresh = 1'b1;
  endtask

  task automatic trap_idle(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      step(idle());
    end
  endtask

  // Script of one instruction; rst_mem >= 0 asserts reset in that MEM cycle.
  task automatic run_instr(input logic [6:0] f, input logic [4:0] alu, input int iwait,
                           input int dwait, input logic br, input int rst_mem);
    exp_t e;
    for (int j = 0; j <= iwait; j++) begin
      noise();
      imem_ready = (j == iwait);
      e = idle();
      e.imem_req = !fresh;
      fresh = 1'b0;
      step(e);
      if (j == LIMIT - 1 && j != iwait) begin
        m_trapped = 1'b1;
        m_cause   = 2'd2;
        return;
      end
    end
    noise();
    {dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_auipc, dec_regwrite} = f;
    dec_aluctrl = alu;
    e = idle();
    e.ir_we = 1'b1;
    step(e);
    if (alu == 5'h0F) begin
      m_trapped = 1'b1;
      m_cause   = 2'd1;
      return;
    end
    noise();
    br_taken = br;
    e = idle();
    e.alu_we = 1'b1;
    if (f[4]) begin
      e.pc_we  = 1'b1;
      e.pc_src = br ? 2'd1 : 2'd0;
    end
    step(e);
    if (f[4]) begin
      m_retired++;
      return;
    end
    if (f[6] || f[5]) begin
      for (int j = 0; j <= dwait; j++) begin
        noise();
        dmem_ready = (j == dwait);
        e = idle();
        e.dmem_req = 1'b1;
        e.dmem_we  = f[5];
        if (j == rst_mem) begin
          chk("dmem_req_before_reset", 64'(dmem_req), 64'd1);
          #2 rst_n = 1'b0;
          #1;
          chk("dmem_req_async_drop", 64'(dmem_req), 64'd0);
          chk("imem_req_async_drop", 64'(imem_req), 64'd0);
          model_reset();
          step(idle());
          return;
        end
        step(e);
        if (j == LIMIT - 1 && j != dwait) begin
          m_trapped = 1'b1;
          m_cause   = 2'd3;
          return;
        end
      end
    end
    noise();
    e = idle();
    e.pc_we  = 1'b1;
    e.rf_we  = f[0] && !f[5];
    e.wb_sel = f[6] ? 2'd1 : ((f[3] || f[2]) ? 2'd2 : 2'd0);
    e.pc_src = f[3] ? 2'd1 : (f[2] ? 2'd2 : 2'd0);
    step(e);
    m_retired++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int base;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(F_ADDI, 5'h00, 0, 0, 1'b0, -1);
    chk("addi_retired", 64'(retired), 64'd1);

    base = n_dreq;
    run_instr(F_LW, 5'h00, 0, 3, 1'b0, -1);
    chk("lw_dmem_req_cycles", 64'(n_dreq - base), 64'd4);
    chk("lw_retired", 64'(retired), 64'd2);

    base = n_rfwe;
    run_instr(F_BEQ, 5'h08, 0, 0, 1'b1, -1);
    run_instr(F_BEQ, 5'h08, 1, 0, 1'b0, -1);
    chk("beq_no_rf_we", 64'(n_rfwe - base), 64'd0);
    chk("beq_retired", 64'(retired), 64'd4);

    run_instr(F_JALR,  5'h00, 0, 0, 1'b0, -1);
    run_instr(F_JAL,   5'h00, 2, 0, 1'b0, -1);
    run_instr(F_AUIPC, 5'h00, 0, 0, 1'b0, -1);
    base = n_rfwe;
    run_instr(F_SW,    5'h00, 0, 0, 1'b0, -1);
    run_instr(F_SW_RW, 5'h00, 0, 2, 1'b0, -1);
    chk("sw_no_rf_we", 64'(n_rfwe - base), 64'd0);

    // ready arriving on the saturating cycle must win over the watchdog
    run_instr(F_ADDI, 5'h01, LIMIT - 1, 0, 1'b0, -1);
    run_instr(F_LW,   5'h00, 0, LIMIT - 1, 1'b0, -1);
    chk("coincide_no_trap", 64'(trap), 64'd0);
    chk("coincide_retired", 64'(retired), 64'd11);

    run_instr(7'b0000000, 5'h0F, 0, 0, 1'b0, -1);
    base = n_strobe;
    trap_idle(20);
    chk("illegal_strobes", 64'(n_strobe - base), 64'd0);
    chk("illegal_trap", 64'(trap), 64'd1);
    chk("illegal_cause", 64'(trap_cause), 64'd1);
    chk("illegal_retired", 64'(retired), 64'd11);

    do_reset();
    run_instr(F_ADDI, 5'h00, 0, 0, 1'b0, -1);
    base = n_ireq;
    run_instr(F_ADDI, 5'h00, 40, 0, 1'b0, -1);
    chk("imem_timeout_wait_cycles", 64'(n_ireq - base), 64'd15);
    trap_idle(4);
    chk("imem_timeout_cause", 64'(trap_cause), 64'd2);
    chk("imem_timeout_retired", 64'(retired), 64'd1);

    do_reset();
    run_instr(F_ADDI, 5'h00, 0, 0, 1'b0, -1);
    base = n_dreq;
    run_instr(F_LW, 5'h00, 0, 40, 1'b0, -1);
    chk("dmem_timeout_wait_cycles", 64'(n_dreq - base), 64'd15);
    trap_idle(4);
    chk("dmem_timeout_cause", 64'(trap_cause), 64'd3);

    do_reset();
    run_instr(F_ADDI, 5'h00, 0, 0, 1'b0, -1);
    run_instr(F_LW, 5'h00, 0, 5, 1'b0, 2);
    do_reset();
    chk("post_reset_retired", 64'(retired), 64'd0);
    chk("post_reset_trap", 64'(trap), 64'd0);
    run_instr(F_ADDI, 5'h00, 1, 0, 1'b0, -1);
    chk("post_reset_addi_retired", 64'(retired), 64'd1);

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL model_queue_drain: got %0d pending, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
